// File: rtl/eq_pkg.sv
// Shared types and default sizing for the equalizer datapath.
package eq_pkg;
  typedef logic signed [15:0] smpl_t;

  typedef enum logic {IDLE, SEQ} q_state_t;

  localparam int HP_TAPS = 1021;
  localparam int Q_DEPTH = 1024;
endpackage

// File: rtl/dp_ram_queue.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module dp_ram_queue #(
  parameter int DEPTH = 1024,
  parameter int W     = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds its value when re is low so the FIR sees a stable sample in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/hp_smpl_queue.sv
// Stereo sample history for the high-pass FIR: stores samples and replays the
// newest TAPS of them oldest-first, framed by 'sequencing'.
module hp_smpl_queue
  import eq_pkg::*;
#(
  parameter int DEPTH  = Q_DEPTH,
  parameter int TAPS   = HP_TAPS,
  parameter int SMPL_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wrt_smpl,
  input  logic signed [SMPL_W-1:0] lft_smpl,
  input  logic signed [SMPL_W-1:0] rght_smpl,
  output logic signed [SMPL_W-1:0] lft_out,
  output logic signed [SMPL_W-1:0] rght_out,
  output logic                     sequencing
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(TAPS + 1);
  localparam logic [CW-1:0] TAPS_C  = CW'(TAPS);
  localparam logic [CW-1:0] TAPS_M1 = CW'(TAPS - 1);

  q_state_t        state, state_nxt;
  logic [PW-1:0]   new_ptr, new_ptr_nxt;
  logic [PW-1:0]   rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [CW-1:0]   seq_cnt, seq_cnt_nxt;
  logic            pend, pend_nxt;
  logic            rd_en;
  logic [2*SMPL_W-1:0] rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      new_ptr <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      seq_cnt <= '0;
      pend    <= 1'b0;
    end else begin
      state   <= state_nxt;
      new_ptr <= new_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      cnt     <= cnt_nxt;
      seq_cnt <= seq_cnt_nxt;
      pend    <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rd_ptr_nxt  = rd_ptr;
    seq_cnt_nxt = seq_cnt;
    pend_nxt    = pend;
    rd_en       = 1'b0;
    new_ptr_nxt = wrt_smpl ? new_ptr + 1'b1 : new_ptr;
    cnt_nxt     = (wrt_smpl && cnt != TAPS_C) ? cnt + 1'b1 : cnt;
    unique case (state)
      IDLE: begin
        // Window base is taken after this cycle's write so a launching sample is included.
        if ((wrt_smpl && cnt >= TAPS_M1) || pend) begin
          state_nxt   = SEQ;
          rd_ptr_nxt  = new_ptr_nxt - PW'(TAPS);
          seq_cnt_nxt = '0;
          pend_nxt    = 1'b0;
        end
      end
      SEQ: begin
        // The final cycle would read the slot past the window; suppress it so outputs hold.
        rd_en       = (seq_cnt != TAPS_C);
        rd_ptr_nxt  = rd_ptr + 1'b1;
        seq_cnt_nxt = seq_cnt + 1'b1;
        if (wrt_smpl)          pend_nxt  = 1'b1;
        if (seq_cnt == TAPS_C) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  dp_ram_queue #(.DEPTH(DEPTH), .W(2*SMPL_W)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wrt_smpl),
    .waddr (new_ptr),
    .wdata ({lft_smpl, rght_smpl}),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign {lft_out, rght_out} = rd_data;
  assign sequencing = (state == SEQ);
endmodule

// File: tb/tb_hp_smpl_queue.sv
// Scoreboard bench for hp_smpl_queue: stimulus pushes expected replay windows,
// an independent monitor pops them while sequencing is high.
module tb_hp_smpl_queue;
  localparam int DEPTH = 1024;
  localparam int TAPS  = 1021;
  localparam int W     = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                wrt_smpl = 1'b0;
  logic signed [W-1:0] lft_smpl = '0;
  logic signed [W-1:0] rght_smpl = '0;
  logic signed [W-1:0] lft_out;
  logic signed [W-1:0] rght_out;
  logic                sequencing;

  always #5 clk = ~clk;

  hp_smpl_queue #(.DEPTH(DEPTH), .TAPS(TAPS), .SMPL_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wrt_smpl   (wrt_smpl),
    .lft_smpl   (lft_smpl),
    .rght_smpl  (rght_smpl),
    .lft_out    (lft_out),
    .rght_out   (rght_out),
    .sequencing (sequencing)
  );

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] hist[$];
  logic [2*W-1:0] exp_q[$];
  int pend_wins = 0;
  int n_seq = 0;
  int last_gap = 0;
  int low_run = 0;
  int k = 0;
  bit inseq = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic wr(input logic [W-1:0] l, input logic [W-1:0] r);
    wrt_smpl  = 1'b1;
    lft_smpl  = l;
    rght_smpl = r;
    hist.push_back({l, r});
    @(posedge clk);
    #1;
    wrt_smpl = 1'b0;
  endtask

  // Expected replay = the newest TAPS samples written, oldest first.
  function automatic void push_window();
    for (int i = hist.size() - TAPS; i < hist.size(); i++) exp_q.push_back(hist[i]);
    pend_wins++;
  endfunction

  task automatic wait_nseq(input int target);
    for (int i = 0; i < 5000 && n_seq < target; i++) @(posedge clk);
    #1;
    chk("wait_seq_start", longint'(n_seq >= target), 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000 && sequencing; i++) begin
      @(posedge clk);
      #1;
    end
    chk("wait_idle", sequencing, 0);
  endtask

  // Monitor
  initial begin
    logic [2*W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        inseq   = 0;
        low_run = 0;
        continue;
      end
      if (sequencing) begin
        if (!inseq) begin
          inseq    = 1;
          k        = 0;
          n_seq++;
          last_gap = low_run;
          chk("seq_expected", longint'(pend_wins > 0), 1);
          if (pend_wins > 0) pend_wins--;
        end else begin
          k++;
        end
        if (k >= 1 && k <= TAPS) begin
          if (exp_q.size() == 0) begin
            chk("replay_data_avail", 0, 1);
          end else begin
            e = exp_q.pop_front();
            chk("replay_lft",  $signed(lft_out),  $signed(e[2*W-1:W]));
            chk("replay_rght", $signed(rght_out), $signed(e[W-1:0]));
          end
        end
      end else begin
        if (inseq) begin
          chk("seq_len", k + 1, TAPS + 1);
          inseq   = 0;
          low_run = 0;
        end
        low_run++;
      end
    end
  end

  initial begin
    // Reset held with inputs toggling
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      wrt_smpl  = 1'($urandom);
      lft_smpl  = W'($urandom);
      rght_smpl = W'($urandom);
      @(negedge clk);
      chk("rst_sequencing", sequencing, 0);
      chk("rst_lft_out", lft_out, 0);
      chk("rst_rght_out", rght_out, 0);
    end
    wrt_smpl = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 1; i <= TAPS - 1; i++) wr(W'(i), W'(-i));
    chk("no_seq_before_full", n_seq, 0);
    chk("seq_low_before_full", sequencing, 0);
    wr(W'(TAPS), W'(-TAPS));
    push_window();
    chk("seq_rise_after_full", sequencing, 1);

    // Second sample at spacing 1024: two idle cycles between replays
    repeat (1023) @(posedge clk);
    #1;
    wr(16'd1022, -16'sd1022);
    push_window();
    @(negedge clk);
    #1;
    chk("gap_between_seqs", last_gap, 1024 - (TAPS + 1));

    // Writes during a replay: all stored, one pending replay of the newest window
    for (int v = 1023; v <= 1099; v++) wr(W'(v), W'(-v));
    push_window();
    wait_nseq(3);
    chk("pend_gap", last_gap, 1);

    // Window crossing the address wrap
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    wr(16'd1100, -16'sd1100);
    push_window();
    chk("seq_rise_wrap", sequencing, 1);

    // Strobe in the final SEQ cycle
    repeat (TAPS) @(posedge clk);
    #1;
    wr(16'd1101, -16'sd1101);
    push_window();
    chk("idle_slot_after_pend", sequencing, 0);
    @(posedge clk);
    #1;
    chk("relaunch_after_pend", sequencing, 1);

    // Reset in the middle of a replay
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    wr(16'd1102, -16'sd1102);
    push_window();
    repeat (500) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sequencing", sequencing, 0);
    chk("async_rst_lft", lft_out, 0);
    chk("async_rst_rght", rght_out, 0);
    exp_q.delete();
    hist.delete();
    pend_wins = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < TAPS - 1; i++) wr(W'($urandom), W'($urandom));
    chk("no_seq_after_reset_fill", n_seq, 6);
    wr(W'($urandom), W'($urandom));
    push_window();
    chk("seq_rise_after_reset_fill", sequencing, 1);
    wait_nseq(7);
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("total_seqs", n_seq, 7);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("windows_consumed", pend_wins, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
